// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative multiply/divide unit for the EX stage.
//   Shift-add multiply and restoring divide, one bit per clock, with sign
//   fix-up in a final FIX cycle. Results land in HI/LO and hold until the
//   next completed operation.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   start_i  : request an operation (sampled only in IDLE)
//   op_i     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush_i  : abort the in-flight operation; also drops a start in IDLE
//   data1_i  : rs operand (multiplicand / dividend)
//   data2_i  : rt operand (multiplier / divisor)
//   busy_o   : operation in progress (registered)
//   done_o   : one-cycle pulse, hi_o/lo_o updated this cycle
//   dbz_o    : divide-by-zero, valid with done_o
//   hi_o     : product high half / remainder
//   lo_o     : product low half / quotient
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_is_div;
    logic               r_neg_q;      // product sign (MULT) / quotient sign (DIV)
    logic               r_neg_r;      // remainder sign = dividend sign
    logic               r_dbz_pend;
    logic [CNT_W-1:0]   r_cnt;
    // MULT: {partial product, remaining multiplier}; DIV: low half holds the
    // dividend shifting out and the quotient shifting in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_b;          // multiplicand / divisor magnitude
    logic               r_busy, r_done, r_dbz;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_accept, w_iter, w_finish;

    // ---------------- operand capture ----------------
    logic               w_sgn, w_neg1, w_neg2, w_dbz_req;
    logic [WIDTH-1:0]   w_mag1, w_mag2;

    assign w_sgn     = ~op_i[0];
    assign w_neg1    = w_sgn & data1_i[WIDTH-1];
    assign w_neg2    = w_sgn & data2_i[WIDTH-1];
    // -MIN wraps back to MIN, which read unsigned is exactly 2^(W-1).
    assign w_mag1    = w_neg1 ? -data1_i : data1_i;
    assign w_mag2    = w_neg2 ? -data2_i : data2_i;
    assign w_dbz_req = op_i[1] & (data2_i == '0);

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;

    // Upper half gets the carry bit so the add never loses its MSB before
    // the right shift.
    assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

    assign w_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_diff    = {1'b0, w_shift} - {2'b0, r_b};
    assign w_qbit    = ~w_diff[WIDTH+1];

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rmd;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start_i && !flush_i)
                        w_state_nxt = w_dbz_req ? S_FIX : S_CALC;
            S_CALC: if (flush_i)              w_state_nxt = S_IDLE;
                    else if (r_cnt == LAST_IT) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        w_accept = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            S_IDLE:  w_accept = start_i & ~flush_i;
            S_CALC:  w_iter   = ~flush_i;
            S_FIX:   w_finish = ~flush_i;
            default: ;
        endcase
    end

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_b        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_finish;
            r_dbz  <= w_finish & r_dbz_pend;

            if (w_accept) begin
                r_is_div   <= op_i[1];
                r_neg_q    <= w_neg1 ^ w_neg2;
                r_neg_r    <= w_neg1;
                r_dbz_pend <= w_dbz_req;
                r_cnt      <= '0;
                r_rem      <= '0;
                r_b        <= op_i[1] ? w_mag2 : w_mag1;
                // Divide-by-zero keeps the raw dividend so HI returns it as-is.
                r_acc      <= {{WIDTH{1'b0}},
                               op_i[1] ? (w_dbz_req ? data1_i : w_mag1) : w_mag2};
            end else if (w_iter) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_is_div) begin
                    r_rem            <= w_qbit ? w_diff[WIDTH:0] : w_shift;
                    r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_qbit};
                end else begin
                    r_acc <= w_mul_nxt;
                end
            end

            if (w_finish) begin
                if (r_dbz_pend) begin
                    r_hi <= r_acc[WIDTH-1:0];
                    r_lo <= '1;
                end else if (r_is_div) begin
                    r_hi <= w_rmd;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign dbz_o  = r_dbz;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the pipelined core.
- Adds MULT/MULTU/DIV/DIVU with HI/LO result registers, which the current single-cycle ALU datapath lacks.
- Operands are taken from the forwarded rs/rt datapath values.
- busy_o feeds the hazard unit, which stalls PC and IF_ID while an operation runs.
- Multiplication is shift-add and division is restoring, both one bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4. Iteration counter width is clog2(WIDTH+1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  request a new operation; sampled only in IDLE
- op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start_i
- flush_i  input  1  abort the in-flight operation (branch/jump flush)
- data1_i  input  WIDTH  rs operand (multiplicand / dividend)
- data2_i  input  WIDTH  rt operand (multiplier / divisor)
- busy_o  output  1  operation in progress; registered
- done_o  output  1  one-cycle pulse: hi_o/lo_o updated this cycle; registered
- dbz_o  output  1  divide-by-zero flag; valid only while done_o=1
- hi_o  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo_o  output  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Reset (rst_i=1 at an edge, overrides everything):
  - state goes to IDLE.
  - busy_o=0, done_o=0, dbz_o=0, hi_o=0, lo_o=0.
  - Counter and operand shadows are cleared.
- States: IDLE, CALC, FIX.
- IDLE, start_i=1 at edge 0:
  - Latch op, the operand magnitudes (signed ops take |x|) and the result sign flags.
  - Enter CALC; busy_o=1 from the next cycle.
  - Exception: a DIV/DIVU with data2_i=0 goes straight to FIX with the dbz flag set.
- CALC: one iteration per edge, for edges 1..WIDTH.
  - MULT: 2W-bit accumulator shift-add on the multiplier LSB.
  - DIV: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Enter FIX after WIDTH iterations.
- FIX, at edge WIDTH+1:
  - Apply the sign fix. Signed MULT negates the 2W-bit product if sign1^sign2. Signed DIV: quotient negated if sign1^sign2; remainder takes the sign of the dividend.
  - Write hi_o/lo_o.
  - done_o=1 for exactly one cycle; busy_o=0 in that same cycle; return to IDLE.
- Latency:
  - Normal operation: done_o is visible WIDTH+1 cycles after the accept edge; busy_o is high for WIDTH+1 cycles.
  - Divide-by-zero: latency 1. Result hi_o=data1_i (unaltered), lo_o=all ones, dbz_o=1.
- Overflow, DIV of MIN by -1: lo_o=MIN, hi_o=0, dbz_o=0. No trap.
- start_i while busy_o=1 is ignored; no queueing.
- start_i in the done_o cycle is accepted (back-to-back operation).
- flush_i=1 at any edge while CALC/FIX is active:
  - Return to IDLE; busy_o=0 next cycle.
  - No done_o pulse; hi_o/lo_o keep their previous values.
- flush_i and start_i together in IDLE: flush_i wins and the start is dropped.
- flush_i has no effect in IDLE otherwise.
- Rules for hi_o/lo_o:
  - They change only in FIX or on reset, and hold between operations.
  - dbz_o is cleared on the cycle after done_o.
- Arithmetic:
  - Unsigned internal magnitudes are WIDTH bits; |MIN| is represented as 2^(W-1) unsigned.
  - The divide remainder register is WIDTH+1 bits so the trial subtract does not overflow.

Test Plan (WIDTH=32):
- MULT, data1=-3, data2=7 → done_o after exactly 33 cycles; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; busy_o high for 33 cycles.
- MULTU, 0xFFFFFFFF×0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001. Then DIVU 100/7 started in the done_o cycle → lo_o=14, hi_o=2, 33 cycles later.
- DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0, dbz_o=0.
- DIVU 5/0 → done_o 1 cycle after accept; dbz_o=1, hi_o=5, lo_o=0xFFFFFFFF; dbz_o=0 on the following cycle.
- MULT 6×7 with flush_i at cycle 10 → busy_o=0 at cycle 11; no done_o; hi_o/lo_o retain the prior result.
- Repeat that flush scenario with rst_i at cycle 10 instead → all outputs 0.
- start_i pulsed every cycle during a busy DIV → only the first request executes; exactly one done_o pulse.
